softmax_bwd: RTL and testbench

Backward pass of the row softmax used in the attention score path. Takes one softmax output row y and its upstream gradient dy and returns dx_i = y_i·(dy_i − Σ_j y_j·dy_j). All values are Q2.13 (value = signed raw / 8192). It runs one time-multiplexed multiplier over a level-held start, mirroring the forward softmax's I_START/O_VLD protocol so the two can share a controller.

---
 rtl/mha_fxp_pkg.sv | 27 ++
 rtl/fxp_mul_q13.sv | 12 +
 rtl/softmax_bwd.sv | 113 +++++++++++
 tb/tb_softmax_bwd.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mha_fxp_pkg.sv
// Shared Q2.13 fixed-point definitions for the forward and backward softmax blocks.
package mha_fxp_pkg;

  localparam int FRAC_W = 13;
  localparam int D_W    = 16;

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (D_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (D_W - 1));

  typedef enum logic [2:0] {
    IDLE,
    DOT,
    SCALE,
    DONE,
    HOLD
  } state_t;

  // Callers sign-extend any narrower intermediate to 64 bits before clamping.
  function automatic logic signed [D_W-1:0] sat(input logic signed [63:0] v);
    logic signed [63:0] c;
    if (v > SAT_MAX) c = SAT_MAX;
    else if (v < SAT_MIN) c = SAT_MIN;
    else c = v;
    return c[D_W-1:0];
  endfunction

endpackage

// File: rtl/fxp_mul_q13.sv
// Single signed D_W x (D_W+1) multiplier; scaling and saturation are left to the caller.
module fxp_mul_q13 #(
  parameter int D_W = 16
) (
  input  logic signed [D_W-1:0]   a,
  input  logic signed [D_W:0]     b,
  output logic signed [2*D_W:0]   p
);

  assign p = (2*D_W+1)'(a) * (2*D_W+1)'(b);

endmodule

// File: rtl/softmax_bwd.sv
// Softmax backward pass: dx_i = y_i * (dy_i - sum_j y_j*dy_j), one shared multiplier.
//
// state | meaning
// IDLE  | waiting for start; latches Y/DY and clears acc when start is seen
// DOT   | accumulate y[cnt]*dy[cnt] over DIM cycles
// SCALE | write dx[cnt] = sat((y[cnt]*(dy[cnt]-s)) >>> 13) over DIM cycles
// DONE  | O_VLD pulse
// HOLD  | result held until start drops
module softmax_bwd #(
  parameter int D_W = 16,
  parameter int DIM = 4
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_START,
  input  logic [D_W*DIM-1:0] I_Y,
  input  logic [D_W*DIM-1:0] I_DY,
  output logic               O_VLD,
  output logic [D_W*DIM-1:0] O_DATA
);
  import mha_fxp_pkg::*;

  localparam int CNT_W  = $clog2(DIM);
  localparam int ACC_W  = 2*D_W + CNT_W;
  localparam int PROD_W = 2*D_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIM - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [D_W-1:0]   y_r  [DIM];
  logic signed [D_W-1:0]   dy_r [DIM];
  logic signed [ACC_W-1:0] acc;
  logic [D_W*DIM-1:0]      data_q;

  logic signed [D_W-1:0]    y_cur, dy_cur, s, dx;
  logic signed [D_W:0]      diff, mul_b;
  logic signed [PROD_W-1:0] mul_p;

  assign y_cur  = y_r[cnt];
  assign dy_cur = dy_r[cnt];

  // acc is frozen through SCALE, so s can be derived combinationally.
  assign s     = sat(64'(acc >>> FRAC_W));
  assign diff  = (D_W+1)'(dy_cur) - (D_W+1)'(s);
  assign mul_b = (state == SCALE) ? diff : (D_W+1)'(dy_cur);
  assign dx    = sat(64'(mul_p >>> FRAC_W));

  fxp_mul_q13 #(.D_W(D_W)) u_mul (
    .a(y_cur),
    .b(mul_b),
    .p(mul_p)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (I_START) state_nxt = DOT;
      DOT: begin
        if (!I_START)         state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = SCALE;
      end
      SCALE: begin
        if (!I_START)         state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = HOLD;
      HOLD:    if (!I_START) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      data_q <= '0;
      y_r    <= '{default: '0};
      dy_r   <= '{default: '0};
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (I_START) begin
            for (int k = 0; k < DIM; k++) begin
              y_r[k]  <= I_Y[k*D_W +: D_W];
              dy_r[k] <= I_DY[k*D_W +: D_W];
            end
            acc <= '0;
            cnt <= '0;
          end
        end
        DOT: begin
          if (I_START) begin
            acc <= acc + ACC_W'(mul_p);
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          end
        end
        SCALE: begin
          if (I_START) begin
            data_q[int'(cnt)*D_W +: D_W] <= dx;
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign O_VLD  = (state == DONE);
  assign O_DATA = data_q;

endmodule

// File: tb/tb_softmax_bwd.sv
// Directed bench for softmax_bwd with a plain-arithmetic reference model and per-cycle compare.
module tb_softmax_bwd;

  localparam int DW = 16;
  localparam int N  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DW*N-1:0]   y = '0;
  logic [DW*N-1:0]   dy = '0;
  logic              vld;
  logic [DW*N-1:0]   data;

  int                errors = 0;
  int                checks = 0;
  int unsigned       cyc = 0;
  logic [31:0]       exp_cyc [$];
  logic [63:0]       exp_dat [$];
  logic              chk_hold = 1'b0;

  softmax_bwd #(.D_W(DW), .DIM(N)) dut (
    .I_CLK  (clk),
    .I_RST_N(rst_n),
    .I_START(start),
    .I_Y    (y),
    .I_DY   (dy),
    .O_VLD  (vld),
    .O_DATA (data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [63:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // dx_i = y_i * (dy_i - sat(floor(sum y*dy / 8192))), each lane floored then clamped.
  function automatic logic [63:0] model(input logic [63:0] yv, input logic [63:0] dyv);
    longint yk [N];
    longint dk [N];
    longint dot, s, v;
    logic [63:0] r;
    dot = 0;
    for (int k = 0; k < N; k++) begin
      yk[k] = longint'($signed(yv[k*16 +: 16]));
      dk[k] = longint'($signed(dyv[k*16 +: 16]));
      dot += yk[k] * dk[k];
    end
    s = clamp16(dot >>> 13);
    r = '0;
    for (int k = 0; k < N; k++) begin
      v = (yk[k] * (dk[k] - s)) >>> 13;
      r[k*16 +: 16] = 16'(clamp16(v));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  // Single checker: model pins, then every cycle compare against the scoreboard.
  initial begin : compare
    int rd;
    logic exp_v;
    logic [63:0] last;
    logic have_last;
    rd = 0;
    have_last = 1'b0;
    last = '0;
    chk("pin_onehot",  model(pack(2048, 2048, 2048, 2048), pack(8192, 0, 0, 0)),
        64'hFE00_FE00_FE00_0600);
    chk("pin_uniform", model(pack(2048, 2048, 2048, 2048), pack(4096, 4096, 4096, 4096)),
        64'h0);
    chk("pin_sat",     model(pack(32767, 32767, 0, 0), pack(32767, -32768, 0, 0)),
        64'h0000_0000_8000_7FFF);
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_vld",  64'(vld), 64'h0);
        chk("rst_data", data, 64'h0);
      end else begin
        exp_v = (rd < exp_cyc.size()) && (exp_cyc[rd] == cyc);
        chk("vld", 64'(vld), 64'(exp_v));
        if (exp_v) begin
          chk("dx", data, exp_dat[rd]);
          last = exp_dat[rd];
          have_last = 1'b1;
          rd++;
        end else if (chk_hold && have_last) begin
          chk("hold_data", data, last);
        end
      end
    end
  end

  // Start held for 'hold' cycles (>=10), then dropped for exactly one cycle.
  task automatic job(input logic [63:0] yv, input logic [63:0] dyv, input int hold, input logic hc);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    y = yv;
    dy = dyv;
    exp_cyc.push_back(cyc + 9);
    exp_dat.push_back(model(yv, dyv));
    @(negedge clk);
    y = {$urandom, $urandom};
    dy = {$urandom, $urandom};
    repeat (9) @(negedge clk);
    chk_hold = hc;
    repeat (hold - 10) @(negedge clk);
    chk_hold = 1'b0;
    start = 1'b0;
  endtask

  logic [63:0] y1h, dy1h, yun, dyun, ysat, dysat, ymix, dymix;

  initial begin : stim
    y1h   = pack(2048, 2048, 2048, 2048);
    dy1h  = pack(8192, 0, 0, 0);
    yun   = y1h;
    dyun  = pack(4096, 4096, 4096, 4096);
    ysat  = pack(32767, 32767, 0, 0);
    dysat = pack(32767, -32768, 0, 0);
    ymix  = pack(1000, 3000, 2000, 2192);
    dymix = pack(-8192, 4096, 123, -5000);

    // reset held with start high; release inside the first job
    start = 1'b1;
    y = y1h;
    dy = dy1h;
    repeat (3) @(negedge clk);
    job(y1h, dy1h, 12, 1'b1);
    job(yun, dyun, 12, 1'b1);
    job(ysat, dysat, 12, 1'b1);
    job(ymix, dymix, 12, 1'b1);

    // abort on the second DOT cycle
    @(negedge clk);
    start = 1'b1;
    y = ymix;
    dy = dymix;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    job(y1h, dy1h, 12, 1'b1);

    // held start: one pulse, stable data, then a single low cycle and new data
    job(ysat, dysat, 40, 1'b1);
    job(ymix, dymix, 12, 1'b1);

    // reset in the middle of SCALE
    @(negedge clk);
    start = 1'b1;
    y = y1h;
    dy = dy1h;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
